ascii_hex_parser: RTL and testbench

Receive-side counterpart to the nibble-to-ASCII hex formatter. Accepts a byte stream of ASCII characters from the debug console path (for example, the UART RX FIFO). Assembles whitespace- or comma-delimited hexadecimal tokens into binary words. Each completed token is presented on a valid/ready output port for the register-access command decoder.

---
 rtl/ascii_hex_pkg.sv | 48 ++++
 rtl/ascii_nibble.sv | 35 +++
 rtl/ascii_hex_parser.sv | 177 +++++++++++++++++
 tb/tb_ascii_hex_parser.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_hex_pkg.sv
// ----------------------------------------------------------------------------
// ascii_hex_pkg
// Shared definitions for the ASCII hex token parser:
//   - ASCII code points for the delimiters, the hex digit ranges and 'x'/'X'
//   - parser state encoding (state_t)
//   - character class encoding (cls_t) produced by ascii_nibble
// ----------------------------------------------------------------------------
package ascii_hex_pkg;

    // Delimiters
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_COMMA = 8'h2C;

    // Hex digit ranges
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_LC_A = 8'h61;
    localparam logic [7:0] CH_LC_F = 8'h66;
    localparam logic [7:0] CH_UC_A = 8'h41;
    localparam logic [7:0] CH_UC_F = 8'h46;

    // Prefix letter
    localparam logic [7:0] CH_LC_X = 8'h78;
    localparam logic [7:0] CH_UC_X = 8'h58;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_EMIT  = 3'd2,
        ST_SKIP  = 3'd3,
        ST_ZERO  = 3'd4,
        ST_PFX   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_HEX     = 2'd0,
        CLS_DELIM   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } cls_t;

    function automatic logic is_prefix_x(input logic [7:0] ch);
        return (ch == CH_LC_X) || (ch == CH_UC_X);
    endfunction

endpackage

// File: rtl/ascii_nibble.sv
// ----------------------------------------------------------------------------
// ascii_nibble
// Combinational ASCII character classifier and hex digit decoder; the inverse
// of the nibble-to-ASCII formatter, accepting both letter cases.
// Ports:
//   ch  [7:0] in   ASCII character
//   cls [1:0] out  CLS_HEX / CLS_DELIM / CLS_ILLEGAL
//   nib [3:0] out  digit value when cls==CLS_HEX, otherwise 0
// ----------------------------------------------------------------------------
module ascii_nibble
    import ascii_hex_pkg::*;
(
    input  logic [7:0] ch,
    output logic [1:0] cls,
    output logic [3:0] nib
);

    always_comb begin
        cls = CLS_ILLEGAL;
        nib = 4'h0;
        if (ch >= CH_0 && ch <= CH_9) begin
            cls = CLS_HEX;
            nib = ch[3:0];
        end else if ((ch >= CH_LC_A && ch <= CH_LC_F) ||
                     (ch >= CH_UC_A && ch <= CH_UC_F)) begin
            // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
            cls = CLS_HEX;
            nib = ch[3:0] + 4'd9;
        end else if (ch == CH_SPACE || ch == CH_TAB || ch == CH_CR ||
                     ch == CH_LF || ch == CH_COMMA) begin
            cls = CLS_DELIM;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// ----------------------------------------------------------------------------
// ascii_hex_parser
// Assembles whitespace/comma delimited ASCII hex tokens into binary words.
// Build option: define HEX_PREFIX_EN to accept an optional "0x"/"0X" prefix.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data[7:0]          ASCII character      (in_valid / in_ready)
//   out_data[4*DIGITS-1:0] assembled word, right-justified
//   out_ndigits[4:0]      digit count of the token
//   out_valid / out_ready output handshake
//   err                   one-cycle pulse per token error
//   err_count[7:0]        saturating error count
// Handshake: a byte moves when in_valid & in_ready are both high on a rising
// edge; a word moves when out_valid & out_ready are both high. out_data and
// out_ndigits stay stable while out_valid is high and out_ready is low.
// ----------------------------------------------------------------------------
module ascii_hex_parser
    import ascii_hex_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [4:0]            out_ndigits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic [7:0]            err_count
);

    localparam int W = 4 * DIGITS;

    state_t       state, state_nxt;
    logic [W-1:0] acc, acc_nxt;
    logic [4:0]   count, count_nxt;
    logic         load_out;
    logic         err_nxt;
    logic         rdy_en;
    logic         take;
    logic [1:0]   cls;
    logic [3:0]   nib;

    ascii_nibble u_nibble (
        .ch  (in_data),
        .cls (cls),
        .nib (nib)
    );

    // rdy_en holds in_ready low for the first cycle after reset releases.
    assign in_ready  = rdy_en && (state != ST_EMIT);
    assign out_valid = (state == ST_EMIT);
    assign take      = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        load_out  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    if (cls == CLS_HEX) begin
                        state_nxt = ST_ACCUM;
                        acc_nxt   = W'(nib);
                        count_nxt = 5'd1;
`ifdef HEX_PREFIX_EN
                        // A leading '0' may be the start of a "0x" prefix.
                        if (in_data == CH_0) state_nxt = ST_ZERO;
`endif
                    end else if (cls == CLS_ILLEGAL) begin
                        state_nxt = ST_SKIP;
                        err_nxt   = 1'b1;
                    end
                end
            end
`ifdef HEX_PREFIX_EN
            ST_ZERO,
`endif
            ST_ACCUM: begin
                if (take) begin
`ifdef HEX_PREFIX_EN
                    if (state == ST_ZERO && is_prefix_x(in_data)) begin
                        // The '0' was a prefix, not a digit.
                        state_nxt = ST_PFX;
                        acc_nxt   = '0;
                        count_nxt = 5'd0;
                    end else
`endif
                    if (cls == CLS_HEX) begin
                        if (count < 5'(DIGITS)) begin
                            state_nxt = ST_ACCUM;
                            acc_nxt   = (acc << 4) | W'(nib);
                            count_nxt = count + 5'd1;
                        end else begin
                            state_nxt = ST_SKIP;
                            acc_nxt   = '0;
                            count_nxt = 5'd0;
                            err_nxt   = 1'b1;
                        end
                    end else if (cls == CLS_DELIM) begin
                        state_nxt = ST_EMIT;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = ST_SKIP;
                        acc_nxt   = '0;
                        count_nxt = 5'd0;
                        err_nxt   = 1'b1;
                    end
                end
            end
`ifdef HEX_PREFIX_EN
            ST_PFX: begin
                if (take) begin
                    if (cls == CLS_HEX) begin
                        state_nxt = ST_ACCUM;
                        acc_nxt   = W'(nib);
                        count_nxt = 5'd1;
                    end else if (cls == CLS_DELIM) begin
                        // "0x" with no digits is an error; the delimiter ends it.
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_SKIP;
                        err_nxt   = 1'b1;
                    end
                end
            end
`endif
            ST_EMIT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                    count_nxt = 5'd0;
                end
            end
            ST_SKIP: begin
                // Rest of a bad token is dropped silently until a delimiter.
                if (take && cls == CLS_DELIM) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                acc_nxt   = '0;
                count_nxt = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            acc         <= '0;
            count       <= 5'd0;
            out_data    <= '0;
            out_ndigits <= 5'd0;
            err         <= 1'b0;
            err_count   <= 8'd0;
            rdy_en      <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            count  <= count_nxt;
            err    <= err_nxt;
            rdy_en <= 1'b1;
            if (load_out) begin
                out_data    <= acc;
                out_ndigits <= count;
            end
            if (err_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
module tb_ascii_hex_parser;

  localparam int DIGITS = 8;
  localparam int W = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] out_data;
  logic [4:0] out_ndigits;
  logic out_valid;
  logic out_ready = 1'b1;
  logic err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  // scoreboard: {ndigits, word}
  logic [W+4:0] exp_q[$];

  ascii_hex_parser #(.DIGITS(DIGITS)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_ndigits(out_ndigits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (err === 1'b1) err_seen++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got %h ndigits %0d, expected no word", out_data, out_ndigits);
        end else begin
          logic [W+4:0] e;
          e = exp_q.pop_front();
          if ({out_ndigits, out_data} !== e)
          begin
            errors++;
            $display("FAIL word_value got %h ndigits %0d, expected %h ndigits %0d",
                     out_data, out_ndigits, e[W-1:0], e[W+4:W]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic is_delim(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A || c == 8'h2C;
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - 8'h30);
    if (c >= "a" && c <= "f") return 4'(c - 8'h61 + 8'd10);
    return 4'(c - 8'h41 + 8'd10);
  endfunction

  // One delimited token: returns 1 if it is an error token, else queues its word.
  function automatic int judge_token(input logic [7:0] tok[$]);
    int start = 0;
    int n;
    logic [63:0] v = 64'd0;
    if (tok.size() == 0) return 0;
`ifdef HEX_PREFIX_EN
    if (tok.size() >= 2 && tok[0] == "0" && (tok[1] == "x" || tok[1] == "X")) begin
      if (tok.size() == 2) return 1;
      start = 2;
    end
`endif
    n = tok.size() - start;
    for (int i = start; i < tok.size(); i++) begin
      if (!is_hex(tok[i])) return 1;
      v = (v << 4) | 64'(hex_val(tok[i]));
    end
    if (n > DIGITS) return 1;
    exp_q.push_back({5'(n), v[W-1:0]});
    return 0;
  endfunction

  function automatic int model_stream(input logic [7:0] s[$]);
    logic [7:0] tok[$];
    int errs = 0;
    for (int i = 0; i < s.size(); i++) begin
      if (is_delim(s[i])) begin
        errs += judge_token(tok);
        tok.delete();
      end else begin
        tok.push_back(s[i]);
      end
    end
    return errs;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout byte %h in_ready %b, expected 1", b, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = "5";
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d expected 0", err_count); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    checks++; if (out_ndigits !== 5'd0) begin errors++; $display("FAIL reset_ndigits got %0d expected 0", out_ndigits); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int e0 = err_seen;
    exp_q.push_back({5'd4, W'(32'h1A2B)});
    send_str("1A2b");
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b expected 0", out_valid); end
    send_byte(8'h0A);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency got %b expected 1", out_valid); end
    checks++; if (out_data !== W'(32'h1A2B)) begin errors++; $display("FAIL basic_data got %h expected 1a2b", out_data); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b expected 0", out_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pending got %0d words expected 0", exp_q.size()); end
    checks++; if (err_seen != e0) begin errors++; $display("FAIL basic_err got %0d pulses expected 0", err_seen - e0); end
  endtask

  task automatic test_delims();
    send_str("  ,");
    send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h09);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL delims_valid got %b expected 0", out_valid); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL delims_err_count got %0d expected 0", err_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    exp_q.push_back({5'd1, W'(5)});
    send_str("12345678");
    send_byte("9");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL overflow_err_pulse got %b expected 1", err); end
    send_byte(" ");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL overflow_err_width got %b expected 0", err); end
    send_str("5 ");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL overflow_err_count got %0d expected 1", err_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overflow_pending got %0d words expected 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    do_reset();
    exp_q.push_back({5'd1, W'(7)});
    send_str("12");
    send_byte("g");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse got %b expected 1", err); end
    send_str("4 7 ");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL illegal_err_count got %0d expected 1", err_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL illegal_pending got %0d words expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit done = 1'b0;
    bit seen = 1'b0;
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back({5'd2, W'(8'hAB)});
    exp_q.push_back({5'd2, W'(8'hCD)});
    fork
      begin
        send_str("AB CD ");
        done = 1'b1;
      end
    join_none
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_no_valid got 0 expected out_valid"); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(8'hAB) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got valid %b data %h in_ready %b expected 1 ab 0", out_valid, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int n = 0; n < 100 && !done; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!done || exp_q.size() != 0) begin errors++; $display("FAIL bp_drain got done %b pending %0d expected 1 0", done, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_reset();
    exp_q.push_back({5'd2, W'(8'h12)});
    exp_q.push_back({5'd2, W'(8'h34)});
    send_byte("1");
    t0 = cyc;
    send_str("2 34 ");
    checks++; if (cyc - t0 != 6) begin errors++; $display("FAIL b2b_cycles got %0d expected 6", cyc - t0); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d words expected 0", exp_q.size()); end
  endtask

  task automatic test_prefix();
    do_reset();
`ifdef HEX_PREFIX_EN
    exp_q.push_back({5'd2, W'(8'h1F)});
    exp_q.push_back({5'd1, W'(0)});
    send_str("0x1F 0 0x");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL prefix_early_err got %b expected 0", err); end
    send_byte(" ");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL prefix_err_pulse got %b expected 1", err); end
`else
    send_str("0");
    send_byte("x");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL prefix_err_pulse got %b expected 1", err); end
    send_str("1F ");
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL prefix_err_count got %0d expected 1", err_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prefix_pending got %0d words expected 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    send_str("34 ");
    checks++; if (out_valid !== 1'b1 || out_data !== W'(8'h34)) begin errors++; $display("FAIL midrst_emit got %b %h expected 1 34", out_valid, out_data); end
    reset = 1'b1; in_valid = 1'b1; in_data = "7";
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", out_valid); end
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({5'd1, W'(5)});
    send_str("5 ");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_pending got %0d words expected 0", exp_q.size()); end
    send_str("77");
    repeat (6) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eos_valid got %b expected 0", out_valid); end
  endtask

  function automatic logic [7:0] rand_char();
    string hx = "0123456789abcdefABCDEF";
    string bad = "gz@x";
    if ($urandom_range(0, 19) == 0) return bad[$urandom_range(0, 3)];
    return hx[$urandom_range(0, 21)];
  endfunction

  function automatic logic [7:0] rand_delim();
    logic [7:0] d[5] = '{8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
    return d[$urandom_range(0, 4)];
  endfunction

  task automatic test_random();
    logic [7:0] stream[$];
    int exp_errs;
    int e0;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      int len = $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) begin
        stream.push_back("0");
        stream.push_back($urandom_range(0, 1) ? "x" : "X");
      end
      for (int k = 0; k < len; k++) stream.push_back(rand_char());
      repeat ($urandom_range(1, 2)) stream.push_back(rand_delim());
    end
    exp_errs = model_stream(stream);
    e0 = err_seen;
    rand_ready = 1'b1;
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i]);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_pending got %0d words expected 0", exp_q.size()); end
    checks++; if (err_seen - e0 != exp_errs) begin errors++; $display("FAIL random_err_pulses got %0d expected %0d", err_seen - e0, exp_errs); end
    checks++; if (int'(err_count) != exp_errs) begin errors++; $display("FAIL random_err_count got %0d expected %0d", err_count, exp_errs); end
  endtask

  task automatic test_saturate();
    int e0;
    do_reset();
    e0 = err_seen;
    for (int i = 0; i < 260; i++) send_str("g ");
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count got %0d expected 255", err_count); end
    checks++; if (err_seen - e0 != 260) begin errors++; $display("FAIL sat_err_pulses got %0d expected 260", err_seen - e0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_delims();
    test_overflow();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_prefix();
    test_mid_reset();
    test_random();
    test_saturate();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
